// File: rtl/fetch_pkg.sv
// Shared widths, the halt encoding and the prefetch buffer entry layout.
package fetch_pkg;

  localparam int INST_W   = 32;
  localparam int IADDR_W  = 8;
  // Widest PC the entry type can carry; narrower PCs are zero-extended.
  localparam int PC_MAX_W = 64;

  localparam logic [INST_W-1:0] HALT_WORD = 32'h00000000;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with flush. A push is
// accepted when full if a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic           do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q];

  // Pointer and occupancy update; flush and reset empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives a combinational ROM from pc_f, buffers fetched
// words in a small FIFO, stops on the halt word, and restarts on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_q,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INST_W-1:0]  inst,
  output logic [N-1:0]       inst_pc,
  output logic               halted
);

  logic [N-1:0]  pc_q, pc_d;
  logic          halted_q, halted_d;
  logic          full, empty;
  logic          pop, fetch, is_halt, push;
  fetch_entry_t  wr_entry, rd_entry;

  assign imem_addr  = pc_q[IADDR_W+1:2];
  assign inst_valid = ~empty;
  assign inst       = rd_entry.inst;
  assign inst_pc    = rd_entry.pc[N-1:0];
  assign halted     = halted_q;

  assign is_halt = (imem_q == HALT_WORD);
  assign pop     = inst_valid & inst_ready & ~redirect;
  assign fetch   = ~halted_q & ~redirect & (~full | pop);
  assign push    = fetch & ~is_halt;

  // Entry built from the current fetch PC and ROM word.
  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = PC_MAX_W'(pc_q);
    wr_entry.inst = imem_q;
  end

  // Next fetch PC and halt flag; redirect outranks normal fetch.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_pc & ~N'(3);
      halted_d = 1'b0;
    end else if (push) begin
      pc_d = pc_q + N'(4);
    end else if (fetch && is_halt) begin
      halted_d = 1'b1;
    end
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a ROM model and hand-computed results.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        halted;

  logic [31:0] rom [256];
  int vectors = 0;
  int errors  = 0;

  assign imem_q = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.N(64), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        found;
    logic [63:0] last_pc;
    logic [31:0] last_inst;

    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 | i;
    rom[0]   = 32'hf8000001;
    rom[1]   = 32'hf8008002;
    rom[2]   = 32'hf8000203;
    rom[92]  = 32'hb400001f;
    rom[93]  = 32'h00000000;
    rom[255] = 32'h8b1f03ff;

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    tick(); tick();
    chk("rst_valid",  {63'd0, inst_valid}, 64'd0);
    chk("rst_addr",   {56'd0, imem_addr}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);

    // Streaming after reset release
    reset = 1'b0;
    tick();
    chk("s0_valid", {63'd0, inst_valid}, 64'd1);
    chk("s0_pc",    inst_pc, 64'h0);
    chk("s0_inst",  {32'd0, inst}, 64'hf8000001);
    tick();
    chk("s1_pc",    inst_pc, 64'h4);
    chk("s1_inst",  {32'd0, inst}, 64'hf8008002);
    tick();
    chk("s2_pc",    inst_pc, 64'h8);
    chk("s2_inst",  {32'd0, inst}, 64'hf8000203);

    // Backpressure from reset
    reset = 1'b1; inst_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_addr",  {56'd0, imem_addr}, 64'd2);
      chk("bp_pc",    inst_pc, 64'h0);
      chk("bp_valid", {63'd0, inst_valid}, 64'd1);
    end
    inst_ready = 1'b1;
    chk("bp_rel0", inst_pc, 64'h0);
    tick();
    chk("bp_rel1", inst_pc, 64'h4);
    tick();
    chk("bp_rel2", inst_pc, 64'h8);

    // Redirect while full
    inst_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 64'h14E;
    tick();
    redirect = 1'b0;
    chk("rd_valid", {63'd0, inst_valid}, 64'd0);
    chk("rd_addr",  {56'd0, imem_addr}, 64'h53);
    inst_ready = 1'b1;
    tick();
    chk("rd_pc",   inst_pc, 64'h14C);
    chk("rd_inst", {32'd0, inst}, {32'd0, rom[83]});

    // Run into the halt word
    found = 1'b0; last_pc = '0; last_inst = '0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (inst_valid) begin
        last_pc = inst_pc;
        last_inst = inst;
      end
      if (halted && !inst_valid) found = 1'b1;
      else tick();
    end
    chk("halt_reached", {63'd0, found}, 64'd1);
    chk("halt_last_pc",   last_pc, 64'h170);
    chk("halt_last_inst", {32'd0, last_inst}, 64'hb400001f);
    chk("halt_addr",      {56'd0, imem_addr}, 64'd93);
    tick(); tick();
    chk("halt_hold",  {63'd0, halted}, 64'd1);
    chk("halt_valid", {63'd0, inst_valid}, 64'd0);
    redirect = 1'b1; redirect_pc = 64'h0;
    tick();
    redirect = 1'b0;
    chk("resume_halted", {63'd0, halted}, 64'd0);
    tick();
    chk("resume_valid", {63'd0, inst_valid}, 64'd1);
    chk("resume_pc",    inst_pc, 64'h0);
    chk("resume_inst",  {32'd0, inst}, 64'hf8000001);

    // ROM address wrap
    redirect = 1'b1; redirect_pc = 64'h3FC;
    tick();
    redirect = 1'b0;
    chk("wrap_addr0", {56'd0, imem_addr}, 64'd255);
    tick();
    chk("wrap_pc0",   inst_pc, 64'h3FC);
    chk("wrap_inst0", {32'd0, inst}, 64'h8b1f03ff);
    chk("wrap_addr1", {56'd0, imem_addr}, 64'd0);
    tick();
    chk("wrap_pc1",   inst_pc, 64'h400);
    chk("wrap_inst1", {32'd0, inst}, 64'hf8000001);

    // Mid-run reset with full FIFO, also overriding a redirect
    inst_ready = 1'b0;
    tick(); tick();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h100;
    tick();
    reset = 1'b0; redirect = 1'b0;
    chk("mrst_valid",  {63'd0, inst_valid}, 64'd0);
    chk("mrst_addr",   {56'd0, imem_addr}, 64'd0);
    chk("mrst_halted", {63'd0, halted}, 64'd0);
    tick();
    chk("mrst_pc",    inst_pc, 64'h0);
    chk("mrst_valid1", {63'd0, inst_valid}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
